// File: rtl/branch_predictor_pkg.sv
// Shared constants and types for the fetch-stage branch predictor.
package branch_predictor_pkg;

    localparam int unsigned IDX_W_DEF = 6;
    localparam int unsigned TAG_W_DEF = 8;

    // 2-bit saturating counter states
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } fd_pred_t;

    // Sequential PC after the branch and its delay slot
    function automatic logic [31:0] next_after_slot(input logic [31:0] pc);
        return pc + 32'd8;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] nxt_c
);

    always_comb begin
        nxt_c = ctr;
        unique case (ctr)
            SNT:     nxt_c = taken ? WNT : SNT;
            WNT:     nxt_c = taken ? WT  : SNT;
            WT:      nxt_c = taken ? ST  : WNT;
            default: nxt_c = taken ? ST  : WT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage direction/target predictor with decode-stage check, training
// and redirect for the 5-stage MIPS pipeline.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEF,
    parameter int unsigned TAG_W = TAG_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        branchD,
    input  logic        takenD,
    input  logic [31:0] targetD,
    output logic        pred_takenF,
    output logic [31:0] pred_targetF,
    output logic        mispredictD,
    output logic [31:0] redirect_pcD
);

    localparam int unsigned DEPTH = 2 ** IDX_W;

    logic [1:0]       ctr_q   [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q   [DEPTH];
    logic [31:0]      tgt_q   [DEPTH];

    fd_pred_t         fd_q;

    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_d;
    logic [TAG_W-1:0] tag_f;
    logic [TAG_W-1:0] tag_d;
    logic [31:0]      pc8_d;
    logic [1:0]       ctr_nxt_c;
    logic             resolve_c;
    logic             alias_c;
    logic             mis_c;

    assign idx_f = pcF[IDX_W+1:2];
    assign tag_f = pcF[IDX_W+TAG_W+1:IDX_W+2];
    assign idx_d = fd_q.pc[IDX_W+1:2];
    assign tag_d = fd_q.pc[IDX_W+TAG_W+1:IDX_W+2];
    assign pc8_d = next_after_slot(fd_q.pc);

    // F lookup reads the pre-update table; no write-to-read bypass
    always_comb begin
        pred_takenF  = ~rst & valid_q[idx_f] & (tag_q[idx_f] == tag_f) & ctr_q[idx_f][1];
        pred_targetF = pred_takenF ? tgt_q[idx_f] : ZeroWord;
    end

    // A stalled D stage neither resolves nor trains; it resolves on release
    assign resolve_c = ~rst & ~stallD & branchD;
    assign alias_c   = ~rst & ~stallD & ~branchD & fd_q.taken;

    always_comb begin
        mis_c        = 1'b0;
        redirect_pcD = ZeroWord;
        if (resolve_c) begin
            mis_c = (takenD != fd_q.taken) |
                    (takenD & fd_q.taken & (targetD != fd_q.target));
            if (mis_c) begin
                redirect_pcD = takenD ? targetD : pc8_d;
            end
        end else if (alias_c) begin
            mis_c        = 1'b1;
            redirect_pcD = pc8_d;
        end
    end

    assign mispredictD = mis_c;

    sat_counter2 u_ctr (
        .ctr   (ctr_q[idx_d]),
        .taken (takenD),
        .nxt_c (ctr_nxt_c)
    );

    // Direction counters, valid bits and the F->D prediction register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= WNT;
            end
            valid_q <= '0;
            fd_q    <= '0;
        end else begin
            if (resolve_c) begin
                ctr_q[idx_d] <= ctr_nxt_c;
                if (takenD) begin
                    valid_q[idx_d] <= 1'b1;
                end
            end else if (alias_c) begin
                valid_q[idx_d] <= 1'b0;
            end

            if (flushD) begin
                fd_q <= '0;
            end else if (!stallD) begin
                fd_q <= '{pc: pcF, taken: pred_takenF, target: pred_targetF};
            end
        end
    end

    // Tag/target payload is qualified by valid_q, so it needs no reset
    always_ff @(posedge clk) begin
        if (!rst && resolve_c && takenD) begin
            tag_q[idx_d] <= tag_d;
            tgt_q[idx_d] <= targetD;
        end
    end

endmodule
